// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with skid-buffered valid/ready
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_R     = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Raw immediate fields, declared signed so the size casts below sign-extend.
    logic signed [11:0] i_field;
    logic signed [11:0] s_field;
    logic signed [12:0] b_field;
    logic signed [20:0] j_field;
    logic signed [31:0] u_field;
    logic        [5:0]  shamt;

    assign i_field = in_instr[31:20];
    assign s_field = {in_instr[31:25], in_instr[11:7]};
    assign b_field = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign j_field = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign u_field = {in_instr[31:12], 12'b0};
    // RV32 shifts are 5 bits wide; bit 25 belongs to the shamt only on RV64.
    assign shamt   = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic            dec_pc_rel;

    // Decode the incoming instruction into immediate, format, target and illegal flag.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        dec_pc_rel  = 1'b0;
        case (in_instr[6:0])
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'(i_field);
            end
            OP_IMM: begin
                if (in_instr[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(shamt);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'(i_field);
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'(s_field);
            end
            OP_BRANCH: begin
                dec_fmt    = FMT_B;
                dec_imm    = XLEN'(b_field);
                dec_pc_rel = 1'b1;
            end
            OP_LUI: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'(u_field);
            end
            OP_AUIPC: begin
                dec_fmt    = FMT_U;
                dec_imm    = XLEN'(u_field);
                dec_pc_rel = 1'b1;
            end
            OP_JAL: begin
                dec_fmt    = FMT_J;
                dec_imm    = XLEN'(j_field);
                dec_pc_rel = 1'b1;
            end
            OP_OP: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        dec_target = dec_pc_rel ? (in_pc + dec_imm) : '0;
    end

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [XLEN-1:0] skid_target;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;

    logic in_fire;
    logic out_fire;
    logic out_load;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready = rst_n && !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_load = !out_valid || out_fire;

    // Output register and skid entry; the skid entry always refills the output first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            out_target   <= '0;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_target  <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_target  <= skid_target;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end else if (in_fire) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_target  <= dec_target;
                out_illegal <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_target  <= dec_target;
            skid_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        rdy32, rdy64;
    logic        v32, v64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt32, fmt64;
    logic        ill32, ill64;

    int n_cmp  = 0;
    int n_fail = 0;

    assign in_pc64 = {32'h0, in_pc};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_target(tgt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_target(tgt64), .out_illegal(ill64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    // Reference decode using weighted field arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit is64);
        exp_t   e;
        longint v   = 0;
        bit     rel = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b1100111: begin
                e.fmt = 3'd1;
                v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
            end
            7'b0010011: begin
                if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
                    e.fmt = 3'd6;
                    v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
                end
            end
            7'b0100011: begin
                e.fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
            end
            7'b1100011: begin
                e.fmt = 3'd3;
                rel = 1;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                    + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'd4;
                rel = (ins[6:0] == 7'b0010111);
                v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
            end
            7'b1101111: begin
                e.fmt = 3'd5;
                rel = 1;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                    + longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
            end
            7'b0110011: e.fmt = 3'd7;
            default:    e.ill = 1'b1;
        endcase
        e.imm = 64'(v);
        e.tgt = rel ? 64'(v + longint'({32'h0, pc})) : 64'h0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h required %h", nm, $time, act, req);
        end
    endtask

    // Scoreboard: model of buffered entries, compared on every falling edge.
    ent_t q[$];
    bit   known    = 0;
    bit   zero_out = 0;

    always @(negedge clk) begin
        exp_t e32, e64;
        bit   acc;
        if (known) begin
            chk("in_ready32", 64'(rdy32), 64'(rst_n && q.size() < 2));
            chk("in_ready64", 64'(rdy64), 64'(rst_n && q.size() < 2));
            chk("out_valid32", 64'(v32), 64'(q.size() > 0));
            chk("out_valid64", 64'(v64), 64'(q.size() > 0));
            if (q.size() > 0) begin
                e32 = model(q[0].ins, q[0].pc, 1'b0);
                e64 = model(q[0].ins, q[0].pc, 1'b1);
                chk("imm32", 64'(imm32), 64'(e32.imm[31:0]));
                chk("fmt32", 64'(fmt32), 64'(e32.fmt));
                chk("tgt32", 64'(tgt32), 64'(e32.tgt[31:0]));
                chk("ill32", 64'(ill32), 64'(e32.ill));
                chk("imm64", imm64, e64.imm);
                chk("fmt64", 64'(fmt64), 64'(e64.fmt));
                chk("tgt64", tgt64, e64.tgt);
                chk("ill64", 64'(ill64), 64'(e64.ill));
            end else if (zero_out) begin
                chk("rst_data32", {imm32, tgt32}, 64'h0);
                chk("rst_flags32", 64'({fmt32, ill32}), 64'h0);
                chk("rst_data64", imm64 | tgt64, 64'h0);
                chk("rst_flags64", 64'({fmt64, ill64}), 64'h0);
            end
        end
        // Advance the model to the state the coming rising edge will produce.
        if (!rst_n) begin
            q.delete();
            known    = 1;
            zero_out = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                q.push_back('{ins: in_instr, pc: in_pc});
                zero_out = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    logic [31:0] vec_ins [14] = '{
        32'h01F09093, 32'h41F0D093, 32'hFE000EE3, 32'hFE006EE3, 32'h800000B7,
        32'h001000EF, 32'h0000007F, 32'h03F09093, 32'hFE112E23, 32'h00812083,
        32'h12345097, 32'h002081B3, 32'hFFC080E7, 32'h80000017
    };
    logic [31:0] vec_pc [14] = '{
        32'h0, 32'h0, 32'h100, 32'h100, 32'h0,
        32'h1000, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h2000, 32'h0, 32'h0, 32'h90000000
    };

    initial begin
        exp_t p;
        bit   acc;

        // Hand-computed values that pin the reference model.
        p = model(32'hFFF00093, 32'h0, 1'b0);
        chk("pin_addi_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_addi_fmt", 64'(p.fmt), 64'd1);
        p = model(32'h41F0D093, 32'h0, 1'b0);
        chk("pin_srai_imm", p.imm, 64'h1F);
        p = model(32'h03F09093, 32'h0, 1'b1);
        chk("pin_slli64_imm", p.imm, 64'h3F);
        p = model(32'hFE006EE3, 32'h100, 1'b0);
        chk("pin_bltu_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pin_bltu_tgt", p.tgt, 64'hFC);
        p = model(32'h800000B7, 32'h0, 1'b1);
        chk("pin_lui_imm", p.imm, 64'hFFFF_FFFF_8000_0000);
        p = model(32'h001000EF, 32'h1000, 1'b0);
        chk("pin_jal_imm", p.imm, 64'h800);
        chk("pin_jal_tgt", p.tgt, 64'h1800);
        p = model(32'h0000007F, 32'h0, 1'b0);
        chk("pin_ill", 64'({p.ill, p.fmt}), 64'h8);
        p = model(32'hFE112E23, 32'h0, 1'b0);
        chk("pin_sw_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        tick;
        tick;
        chk("reset_valid", 64'(v32), 64'h0);
        chk("reset_ready", 64'(rdy32), 64'h0);
        chk("reset_imm", 64'(imm32), 64'h0);
        rst_n = 1'b1;

        put(32'hFFF00093, 32'h0);
        tick;
        in_valid = 1'b0;
        chk("addi_valid", 64'(v32), 64'h1);
        chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(fmt32), 64'h1);
        chk("addi_tgt", 64'(tgt32), 64'h0);

        for (int i = 0; i < 14; i++) begin
            put(vec_ins[i], vec_pc[i]);
            tick;
        end
        in_valid = 1'b0;
        chk("auipc_wrap_tgt", 64'(tgt32), 64'h1000_0000);
        tick;

        // Backpressure: two accepted, third waits until the consumer drains.
        out_ready = 1'b0;
        put(32'h00100093, 32'h0); tick;
        put(32'h00200093, 32'h0); tick;
        put(32'h00300093, 32'h0); tick;
        chk("bp_ready", 64'(rdy32), 64'h0);
        chk("bp_imm", 64'(imm32), 64'h1);
        tick;
        tick;
        chk("bp_hold_imm", 64'(imm32), 64'h1);
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = in_valid && rdy32;
            @(posedge clk);
            #1;
        end
        chk("bp_third_accepted", 64'(acc), 64'h1);
        in_valid = 1'b0;
        tick; tick; tick;

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        put(32'h00400093, 32'h0); tick;
        put(32'h00500093, 32'h0); tick;
        put(32'h00600093, 32'h0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(v32), 64'h0);
        chk("flush_ready", 64'(rdy32), 64'h1);
        out_ready = 1'b1;
        put(32'h00700093, 32'h0); tick;
        in_valid = 1'b0;
        chk("post_flush_imm", 64'(imm32), 64'h7);
        tick;

        // Flush discards an input that would otherwise have been accepted.
        put(32'h00800093, 32'h0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_discard_valid", 64'(v32), 64'h0);
        tick;

        // Reset while entries are buffered and an input is offered.
        out_ready = 1'b0;
        put(32'hFFF00093, 32'h0); tick;
        put(32'h001000EF, 32'h1000); tick;
        rst_n = 1'b0;
        put(32'h00900093, 32'h0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("midrst_valid", 64'(v32), 64'h0);
        chk("midrst_imm", 64'(imm32), 64'h0);
        chk("midrst_ready", 64'(rdy32), 64'h0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, XLEN-parametrised RISC-V immediate generator with a valid/ready handshake on both sides, sitting between fetch and the decode/execute register stage. It extracts and sign-extends the immediate for every RV32I/RV64I base format. It also classifies the format, flags unsupported opcodes, and precomputes the PC-relative target for BRANCH, JAL and AUIPC. Byte offsets are architecturally exact: B and J immediates include the implicit LSB 0, U immediates are shifted by 12, and branch offsets are always signed.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64 only.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  drop all buffered entries (pipeline redirect)
in_valid  in  1  instruction/PC valid
in_ready  out  1  block can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  result valid
out_ready  in  1  consumer accepts this cycle
out_imm  out  XLEN  extended immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 R
out_target  out  XLEN  in_pc+out_imm for BRANCH/JAL/AUIPC, else 0
out_illegal  out  1  opcode not in supported set

Behaviour:
- Opcode map: LOAD 0000011 → I; JALR 1100111 → I; OP-IMM 0010011 → I, or SHAMT when funct3 = 001/101; STORE 0100011 → S; BRANCH 1100011 → B; LUI 0110111 → U; AUIPC 0010111 → U; JAL 1101111 → J; OP 0110011 → R with imm 0; any other opcode → NONE, imm 0, target 0, illegal=1.
- I format: sext(instr[31:20]).
- S format: sext({instr[31:25], instr[11:7]}).
- B format: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), for all funct3 including BLTU/BGEU.
- J format: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- U format: sext({instr[31:12], 12'b0}) to XLEN.
- SHAMT format: zero-extended shift amount; instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. instr[30] (arith select) is ignored.
- Target: XLEN-bit add with wrap-around modulo 2^XLEN; no overflow flag.
- Pipeline structure: one output register plus a one-entry skid register. Latency is 1 cycle from input handshake to out_valid.
- in_ready = rst_n && !skid_valid. The signal is registered-derived and has no combinational path from out_ready.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - The output register loads when it is empty or being drained that cycle; otherwise the accepted entry goes to the skid register.
  - On an output drain, the skid entry (if any) moves to the output register before any new entry.
  - Strict in-order delivery; no entry is lost or duplicated.
- While out_valid && !out_ready, all out_* signals are held stable.
- flush (when rst_n=1): out_valid and skid_valid clear on the next edge. A concurrent input is discarded. in_ready is 1 the following cycle.
- Reset (rst_n=0 at a clock edge, including mid-transfer): out_valid=0, out_imm=0, out_fmt=0, out_target=0, out_illegal=0, skid cleared. in_ready=0 while rst_n=0. Reset has priority over flush.
- Data outputs are registered and change only on an output-register load.

Test Plan:
- Reset, XLEN=32: rst_n=0 for 2 cycles, then in_valid 0xFFF00093 (addi x1,x0,-1) → out_valid next cycle, out_imm=0xFFFFFFFF, fmt=1, illegal=0, target=0. Outputs all 0 during reset.
- Shifts: 0x01F09093 (slli 31) and 0x41F0D093 (srai 31) → both out_imm=0x0000001F, fmt=6. With XLEN=64, 0x03F09093 → 0x3F.
- Branches, pc=0x100: 0xFE000EE3 (beq -4) and 0xFE006EE3 (bltu -4) → both out_imm=0xFFFFFFFC, fmt=3, target=0x000000FC.
- U/J formats:
  - 0x800000B7 (lui) → 0x80000000 at XLEN=32, 0xFFFFFFFF80000000 at XLEN=64.
  - 0x001000EF (jal +2048), pc=0x1000 → imm 0x800, fmt=5, target 0x1800.
  - 0x0000007F → illegal=1, imm 0, fmt 0.
- Backpressure: out_ready=0 while 3 back-to-back inputs are offered → first two accepted, in_ready=0 on the third until out_ready=1. Outputs stay stable while stalled, then all three are delivered in order.
- Flush: with both entries full, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1; the concurrent input never appears at the output.
